fifo_wr_ctrl: RTL and testbench

Write-side pointer and flag controller for the design's asynchronous FIFO, clocked by the write-domain clock. Accepts write requests, produces the RAM write address/enable, publishes a Gray-coded write pointer to the read domain, and derives a registered full flag from the read-domain Gray pointer through a two-flop synchronizer. Pairs with the read-side controller, which mirrors it in the read clock domain.

---
 rtl/fifo_pkg.sv | 22 ++
 rtl/sync_2ff.sv | 26 ++
 rtl/fifo_wr_ctrl.sv | 109 ++++++++++
 tb/tb_fifo_wr_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: default address width and Gray/binary conversions.
// Functions are 32 bits wide; callers zero-extend in and size-cast the result back.
package fifo_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int FN_W       = 32;

  function automatic logic [FN_W-1:0] bin2gray(input logic [FN_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [FN_W-1:0] gray2bin(input logic [FN_W-1:0] g);
    logic [FN_W-1:0] b;
    b          = '0;
    b[FN_W-1]  = g[FN_W-1];
    for (int i = FN_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for multi-bit Gray-coded pointers; async reset to zero.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q1;
  logic [WIDTH-1:0] r_q2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q1 <= '0;
      r_q2 <= '0;
    end else begin
      r_q1 <= d;
      r_q2 <= r_q1;
    end
  end

  assign q = r_q2;

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side pointer/flag controller of the async FIFO (write clock domain).
// Optional macro FIFO_WR_ALMOST_FULL_EN adds the walmost_full and wlevel outputs.
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF
`ifdef FIFO_WR_ALMOST_FULL_EN
  ,
  parameter int AF_THRESH = 2
`endif
) (
  input  logic              clk,
  input  logic              w_rst,
  input  logic              w_en,
  input  logic [ADDR_W:0]   rptr_gray,
  output logic [ADDR_W-1:0] waddr,
  output logic              mem_we,
  output logic [ADDR_W:0]   wptr_gray,
  output logic              wfull,
  output logic              w_ovf
`ifdef FIFO_WR_ALMOST_FULL_EN
  ,
  output logic              walmost_full,
  output logic [ADDR_W:0]   wlevel
`endif
);

  localparam int PW = ADDR_W + 1;

  logic [ADDR_W:0] r_wbin;
  logic [ADDR_W:0] r_wgray;
  logic            r_wfull;
  logic            r_wovf;

  logic            w_accept;
  logic [ADDR_W:0] w_bin_next;
  logic [ADDR_W:0] w_gray_next;
  logic [ADDR_W:0] w_rq2;
  logic            w_full_next;

  // Read pointer crosses into this domain only through the synchronizer.
  sync_2ff #(
    .WIDTH (PW)
  ) u_rptr_sync (
    .clk (clk),
    .rst (w_rst),
    .d   (rptr_gray),
    .q   (w_rq2)
  );

  assign w_accept    = w_en & ~r_wfull;
  assign w_bin_next  = r_wbin + PW'(w_accept);
  assign w_gray_next = PW'(bin2gray(FN_W'(w_bin_next)));

  // Full when the next write pointer has lapped the read pointer once:
  // top two Gray bits inverted, the rest equal.
  assign w_full_next = (w_gray_next == {~w_rq2[ADDR_W:ADDR_W-1], w_rq2[ADDR_W-2:0]});

  always_ff @(posedge clk or posedge w_rst) begin
    if (w_rst) begin
      r_wbin  <= '0;
      r_wgray <= '0;
      r_wfull <= 1'b0;
      r_wovf  <= 1'b0;
    end else begin
      r_wbin  <= w_bin_next;
      r_wgray <= w_gray_next;
      r_wfull <= w_full_next;
      if (w_en && r_wfull) begin
        r_wovf <= 1'b1;
      end
    end
  end

  assign waddr     = r_wbin[ADDR_W-1:0];
  assign mem_we    = w_accept;
  assign wptr_gray = r_wgray;
  assign wfull     = r_wfull;
  assign w_ovf     = r_wovf;

`ifdef FIFO_WR_ALMOST_FULL_EN
  localparam int DEPTH = 2 ** ADDR_W;

  logic [ADDR_W:0] w_rbin_sync;
  logic [ADDR_W:0] w_level_next;
  logic            w_af_next;
  logic [ADDR_W:0] r_wlevel;
  logic            r_walmost_full;

  // Occupancy uses the same stale read pointer as wfull, so it can only over-report.
  assign w_rbin_sync  = PW'(gray2bin(FN_W'(w_rq2)));
  assign w_level_next = w_bin_next - w_rbin_sync;
  assign w_af_next    = (DEPTH - int'(w_level_next)) <= AF_THRESH;

  always_ff @(posedge clk or posedge w_rst) begin
    if (w_rst) begin
      r_wlevel       <= '0;
      r_walmost_full <= 1'b0;
    end else begin
      r_wlevel       <= w_level_next;
      r_walmost_full <= w_af_next;
    end
  end

  assign wlevel       = r_wlevel;
  assign walmost_full = r_walmost_full;
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Bench for fifo_wr_ctrl: directed fill/overflow/drain/wrap/reset steps plus a random
// phase, all checked against an occupancy-count model of the write-side FIFO view.
module tb_fifo_wr_ctrl;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              w_rst;
  logic              w_en;
  logic [ADDR_W:0]   rptr_gray;
  logic [ADDR_W-1:0] waddr;
  logic              mem_we;
  logic [ADDR_W:0]   wptr_gray;
  logic              wfull;
  logic              w_ovf;
`ifdef FIFO_WR_ALMOST_FULL_EN
  logic              walmost_full;
  logic [ADDR_W:0]   wlevel;
`endif

  fifo_wr_ctrl #(
    .ADDR_W    (ADDR_W)
`ifdef FIFO_WR_ALMOST_FULL_EN
    ,
    .AF_THRESH (2)
`endif
  ) dut (
    .clk          (clk),
    .w_rst        (w_rst),
    .w_en         (w_en),
    .rptr_gray    (rptr_gray),
    .waddr        (waddr),
    .mem_we       (mem_we),
    .wptr_gray    (wptr_gray),
    .wfull        (wfull),
    .w_ovf        (w_ovf)
`ifdef FIFO_WR_ALMOST_FULL_EN
    ,
    .walmost_full (walmost_full),
    .wlevel       (wlevel)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Model: total writes accepted, total reads the read side has published,
  // and the read count driven at each clock edge (the write side sees it two edges late).
  int m_wcnt;
  int m_rcnt;
  int m_seen;
  int m_hist[$];
  bit m_full;
  bit m_ovf;

  function automatic logic [4:0] to_gray(input int v);
    logic [4:0] b;
    b = 5'(v % 32);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_wcnt = 0;
    m_rcnt = 0;
    m_seen = 0;
    m_hist.delete();
    m_full = 1'b0;
    m_ovf  = 1'b0;
  endtask

  task automatic chk_regs();
    chk("waddr",     32'(waddr),     32'(m_wcnt % DEPTH));
    chk("wptr_gray", 32'(wptr_gray), 32'(to_gray(m_wcnt)));
    chk("wfull",     32'(wfull),     32'(m_full));
    chk("w_ovf",     32'(w_ovf),     32'(m_ovf));
`ifdef FIFO_WR_ALMOST_FULL_EN
    chk("wlevel",       32'(wlevel),       32'(m_wcnt - m_seen));
    chk("walmost_full", 32'(walmost_full), 32'((DEPTH - (m_wcnt - m_seen)) <= 2));
`endif
  endtask

  // One clock: called just after a rising edge; drives inputs, checks the
  // combinational write port, then advances the model across the next edge.
  task automatic cyc(input bit en);
    bit acc;
    w_en      = en;
    rptr_gray = to_gray(m_rcnt);
    #1;
    chk("mem_we", 32'(mem_we), 32'(en && !m_full));
    @(posedge clk);
    acc    = en && !m_full;
    m_ovf  = m_ovf || (en && m_full);
    m_wcnt = m_wcnt + int'(acc);
    m_seen = (m_hist.size() >= 2) ? m_hist[$-1] : 0;
    m_hist.push_back(m_rcnt);
    m_full = (m_wcnt - m_seen) == DEPTH;
    #1;
    chk_regs();
  endtask

  task automatic do_reset_at_edge();
    w_rst = 1'b1;
    @(posedge clk);
    #1;
    w_rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [4:0] prev_g;
    w_rst     = 1'b1;
    w_en      = 1'b0;
    rptr_gray = '0;
    model_reset();
    @(posedge clk);
    #1;
    chk_regs();
    chk("mem_we_rst", 32'(mem_we), 32'(0));
    w_rst = 1'b0;

    // Fill with read pointer held at zero.
    for (int i = 0; i < DEPTH; i++) begin
      chk("fill_waddr", 32'(waddr), 32'(i));
      cyc(1'b1);
    end
    chk("fill_full", 32'(wfull), 32'(1));
    chk("fill_gray", 32'(wptr_gray), 32'(5'b11000));

    // Overflow attempt, then stickiness across idle cycles.
    cyc(1'b1);
    chk("ovf_set", 32'(w_ovf), 32'(1));
    chk("ovf_ptr", 32'(wptr_gray), 32'(5'b11000));
    cyc(1'b0);
    chk("ovf_sticky", 32'(w_ovf), 32'(1));

    // Drain release: one read published; full drops on the third edge.
    m_rcnt = 1;
    cyc(1'b0);
    chk("drain_e1", 32'(wfull), 32'(1));
    cyc(1'b0);
    chk("drain_e2", 32'(wfull), 32'(1));
    cyc(1'b0);
    chk("drain_e3", 32'(wfull), 32'(0));
    chk("drain_waddr", 32'(waddr), 32'(0));
    cyc(1'b1);
    chk("drain_wr", 32'(waddr), 32'(1));
    chk("ovf_hold", 32'(w_ovf), 32'(1));

    // Asynchronous reset in the middle of a burst.
    cyc(1'b1);
    w_en = 1'b1;
    #2;
    w_rst = 1'b1;
    #1;
    chk("arst_waddr", 32'(waddr),     32'(0));
    chk("arst_gray",  32'(wptr_gray), 32'(0));
    chk("arst_full",  32'(wfull),     32'(0));
    chk("arst_ovf",   32'(w_ovf),     32'(0));
    @(posedge clk);
    #1;
    w_rst = 1'b0;
    model_reset();
    cyc(1'b0);
    chk("post_rst_gray", 32'(wptr_gray), 32'(0));

    // Wrap: 40 writes with the read side trailing two behind.
    prev_g = wptr_gray;
    for (int i = 0; i < 40; i++) begin
      m_rcnt = (m_wcnt >= 2) ? m_wcnt - 2 : 0;
      cyc(1'b1);
      chk("wrap_step", 32'($countones(wptr_gray ^ prev_g)), 32'(1));
      chk("wrap_nofull", 32'(wfull), 32'(0));
      prev_g = wptr_gray;
    end

`ifdef FIFO_WR_ALMOST_FULL_EN
    // Almost-full threshold with read pointer at zero.
    do_reset_at_edge();
    for (int i = 0; i < 13; i++) cyc(1'b1);
    chk("af_13_level", 32'(wlevel), 32'(13));
    chk("af_13_flag",  32'(walmost_full), 32'(0));
    cyc(1'b1);
    chk("af_14_level", 32'(wlevel), 32'(14));
    chk("af_14_flag",  32'(walmost_full), 32'(1));
`endif

    // Random traffic: reads never overtake accepted writes.
    do_reset_at_edge();
    for (int i = 0; i < 400; i++) begin
      if (m_rcnt < m_wcnt && $urandom_range(0, 1) == 1) m_rcnt++;
      cyc($urandom_range(0, 3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
